// File: rtl/ff_pkg.sv
// ff_pkg: default configuration shared by the register bank and its stages.
//   FF_WIDTH_DEF  - default data width
//   FF_STAGES_DEF - default number of cascaded stages
package ff_pkg;

   localparam int FF_WIDTH_DEF  = 4;
   localparam int FF_STAGES_DEF = 1;

endpackage : ff_pkg

// File: rtl/ff_stage.sv
// ff_stage: one WIDTH-bit D register, async active-low reset.
//   clk   in   rising-edge capture clock
//   rst_n in   async active-low reset, loads RESET_VALUE
//   d     in   WIDTH data to capture
//   q     out  WIDTH registered data
module ff_stage
   import ff_pkg::*;
#(
   parameter int                 WIDTH       = FF_WIDTH_DEF,
   parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;

   // No enable: every edge captures.
   always_comb begin
      data_d = d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= RESET_VALUE;
      else        data_q <= data_d;
   end

   assign q = data_q;

endmodule : ff_stage

// File: rtl/ff.sv
// ff: positive-edge D register bank, optionally a STAGES-deep delay line.
//   clk   in   sole clock, rising-edge capture
//   rst_n in   async active-low reset; every stage loads RESET_VALUE
//   d     in   WIDTH data to capture
//   q     out  WIDTH output of the last stage (latency STAGES edges)
module ff
   import ff_pkg::*;
#(
   parameter int                 WIDTH       = FF_WIDTH_DEF,
   parameter int                 STAGES      = FF_STAGES_DEF,
   parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (WIDTH < 1)  begin : g_bad_width
      $error("ff: WIDTH must be >= 1");
   end
   if (STAGES < 1) begin : g_bad_stages
      $error("ff: STAGES must be >= 1");
   end

   // chain[0] is the input, chain[i+1] is the output of stage i.
   logic [WIDTH-1:0] chain [STAGES+1];

   assign chain[0] = d;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      ff_stage #(
         .WIDTH       (WIDTH),
         .RESET_VALUE (RESET_VALUE)
      ) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (chain[i]),
         .q     (chain[i+1])
      );
   end

   assign q = chain[STAGES];

`ifndef SYNTHESIS
   // While reset is held, the output must sit at the reset value.
   a_reset_hold : assert property (@(posedge clk) !rst_n |-> (q == RESET_VALUE))
      else $error("ff: q not at RESET_VALUE during reset");
`endif

endmodule : ff

// File: tb/tb_ff.sv
`timescale 1ns/10ps
// tb_ff: directed bench for ff, default config plus a 3-stage delay line.
module tb_ff;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] d0, d3;
   logic [3:0] q0, q3;

   int n_pass  = 0;
   int n_total = 0;

   ff u_dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d0),
      .q     (q0)
   );

   ff #(
      .WIDTH       (4),
      .STAGES      (3),
      .RESET_VALUE (4'hA)
   ) u_dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d3),
      .q     (q3)
   );

   // Rising edges at t = 0 mod 10.
   initial begin
      forever begin
         clk = 1'b1; #5;
         clk = 1'b0; #5;
      end
   end

   // Model: list of values captured since the last reset. Output is the
   // sample captured STAGES edges ago, or the reset value if not enough yet.
   logic [3:0] hist0 [$];
   logic [3:0] hist3 [$];
   bit         seen_reset = 1'b0;

   always @(posedge clk) begin
      if (rst_n === 1'b1) begin
         hist0.push_back(d0);
         hist3.push_back(d3);
      end
   end

   always @(negedge rst_n) begin
      hist0.delete();
      hist3.delete();
      seen_reset = 1'b1;
   end

   function automatic logic [3:0] model_q(input logic [3:0] h [$], input int stages,
                                          input logic [3:0] rv);
      int n = h.size();
      if (n >= stages) return h[n-stages];
      return rv;
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
   endtask

   // Continuous comparison mid-period, away from the capturing edge.
   always @(negedge clk) begin
      if (seen_reset) begin
         check("model_q0", q0, model_q(hist0, 1, 4'h0));
         check("model_q3", q3, model_q(hist3, 3, 4'hA));
      end
   end

   initial begin
      rst_n = 1'b1;
      d0    = 4'h0;
      d3    = 4'h0;

      #2  rst_n = 1'b0;                         // t=2
      #1  check("rst_q0", q0, 4'b0000);         // t=3
          check("rst_q3", q3, 4'hA);
      #9  check("rst_hold_q0", q0, 4'b0000);    // t=12, edge at 10 ignored
          check("rst_hold_q3", q3, 4'hA);
      #3  rst_n = 1'b0;                         // t=15 falling edge: release
          rst_n = 1'b1;
          d0    = 4'b1100;
          d3    = 4'h3;
      #6  check("cap1_q0", q0, 4'b1100);        // t=21
          check("dly_q3_e1", q3, 4'hA);
      #4  d0 = 4'b0101;                         // t=25
          d3 = 4'h0;
      #6  check("cap2_q0", q0, 4'b0101);        // t=31
          check("dly_q3_e2", q3, 4'hA);
      #1  d0 = 4'b1111;                         // t=32, mid-cycle change
      #3  check("mid_hold_q0", q0, 4'b0101);    // t=35
      #6  check("mid_cap_q0", q0, 4'b1111);     // t=41
          check("dly_q3_e3", q3, 4'h3);
      #2  rst_n = 1'b0;                         // t=43, async reset
      #0.1 check("async_q0", q0, 4'b0000);
           check("async_q3", q3, 4'hA);
      #1.9 rst_n = 1'b1;                        // t=45 falling edge
           d3 = 4'h7;
      #6  check("post_rst_q0", q0, 4'b1111);    // t=51, edge 50 captured
          check("post_rst_q3", q3, 4'hA);
      #4  d0 = 4'h9;                            // t=55
          d3 = 4'h0;
      #10 d0 = 4'h6;                            // t=65
      #6  check("vec_q0", q0, 4'h6);            // t=71
          check("post_rst_q3_dly", q3, 4'h7);
      #4  d0 = 4'h3;                            // t=75
      #30;                                      // t=105
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_ff
